// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states, owner codes
// and the fixed size code used for instruction fetches.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  localparam logic       OWN_IF       = 1'b0;
  localparam logic       OWN_D        = 1'b1;
  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_nbit_reg.sv
// Generic loadable register with asynchronous active-low clear.
// The arbiter uses it to hold the accepted request for the whole access.
module unified_mem_arbiter_nbit_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load on request, cleared asynchronously.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter between instruction fetch and data access for a single-ported
// unified memory with fixed read latency. Data wins over fetch, except that
// fetch is forced through after STARVE_MAX consecutive data grants.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no access in flight; grants are issued combinationally
// ARB_ACCESS | mem_en high for MEM_LAT cycles, write only on the first
// ARB_RESP   | owner's rvalid pulses for one cycle
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = cnt_width(MEM_LAT);
  localparam int ST_W  = cnt_width(STARVE_MAX);
  localparam int CAP_W = ADDR_W + DATA_W + 5;

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);
  localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_MAX);

  arb_state_e state_q, state_d;

  logic [LAT_W-1:0]  lat_cnt_q;
  logic [ST_W-1:0]   starve_cnt_q;
  logic              d_wins;
  logic              gnt_any;
  logic              lat_first;
  logic              lat_done;

  logic [CAP_W-1:0]  cap_d, cap_q;
  logic              cap_owner;
  logic              cap_we;
  logic [2:0]        cap_funct3;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // Data wins unless fetch has been waiting through STARVE_MAX data grants.
  assign d_wins    = d_req && (!if_req || (starve_cnt_q < ST_MAX));
  assign gnt_any   = if_gnt || d_gnt;
  assign lat_first = (lat_cnt_q == LAT_LOAD);
  assign lat_done  = (lat_cnt_q == LAT_LAST);

  // Fetch requests are captured as plain word reads.
  assign cap_d = d_gnt ? {OWN_D, d_we, d_funct3, d_addr, d_wdata}
                       : {OWN_IF, 1'b0, FETCH_FUNCT3, if_addr, {DATA_W{1'b0}}};

  unified_mem_arbiter_nbit_reg #(
    .WIDTH (CAP_W)
  ) u_cap_reg (
    .clk   (clk),
    .clr_n (rst),
    .load  (gnt_any),
    .d     (cap_d),
    .q     (cap_q)
  );

  assign cap_wdata  = cap_q[DATA_W-1:0];
  assign cap_addr   = cap_q[DATA_W +: ADDR_W];
  assign cap_funct3 = cap_q[DATA_W+ADDR_W +: 3];
  assign cap_we     = cap_q[DATA_W+ADDR_W+3];
  assign cap_owner  = cap_q[CAP_W-1];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (gnt_any)  state_d = ARB_ACCESS;
      ARB_ACCESS: if (lat_done) state_d = ARB_RESP;
      ARB_RESP:                 state_d = ARB_IDLE;
      default:                  state_d = ARB_IDLE;
    endcase
  end

  // Outputs: grants while idle (held off during reset), memory drive while accessing.
  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = '0;
    if_rvalid  = 1'b0;
    d_rvalid   = 1'b0;
    busy       = (state_q != ARB_IDLE);
    case (state_q)
      ARB_IDLE: begin
        if (rst) begin
          d_gnt  = d_wins;
          if_gnt = if_req && !d_wins;
        end
      end
      ARB_ACCESS: begin
        mem_en     = 1'b1;
        mem_we     = cap_we && lat_first;
        mem_funct3 = cap_funct3;
        mem_addr   = cap_addr;
        mem_wdata  = cap_wdata;
      end
      ARB_RESP: begin
        if_rvalid = (cap_owner == OWN_IF);
        d_rvalid  = (cap_owner == OWN_D);
      end
      default: ;
    endcase
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  // Latency down-counter: loaded at grant, terminal count ends the access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt_q <= '0;
    end else if (gnt_any) begin
      lat_cnt_q <= LAT_LOAD;
    end else if ((state_q == ARB_ACCESS) && (lat_cnt_q != '0)) begin
      lat_cnt_q <= lat_cnt_q - LAT_W'(1);
    end
  end

  // Consecutive data grants while fetch waits, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else if (d_gnt) begin
      if (!if_req) begin
        starve_cnt_q <= '0;
      end else if (starve_cnt_q < ST_MAX) begin
        starve_cnt_q <= starve_cnt_q + ST_W'(1);
      end
    end else if (if_gnt) begin
      starve_cnt_q <= '0;
    end
  end

  // Register the read data into the owner's channel on the last access cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if ((state_q == ARB_ACCESS) && lat_done) begin
      if (cap_owner == OWN_D) begin
        d_rdata_q <= cap_we ? '0 : mem_rdata;
      end else begin
        if_rdata_q <= mem_rdata;
      end
    end
  end

endmodule
